// File: rtl/saed32_mem_pkg.sv
// Shared defaults, FSM state type and the read-modify-write merge helper for the
// SAED32 32x4 single-port memory controller.
package saed32_mem_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 4;

    // The merge helper works on a fixed wide word; callers widen and narrow around it.
    localparam int MERGE_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RMW_RD,
        RMW_WR
    } state_t;

    function automatic logic [MERGE_W-1:0] merge_bits(
        input logic [MERGE_W-1:0] old_data,
        input logic [MERGE_W-1:0] wdata,
        input logic [MERGE_W-1:0] mask
    );
        return (old_data & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/saed32_32x4_rmw_ctrl.sv
// Request/response front end for a 32x4 single-port SRAM: reads, full writes and
// partial-mask writes done as read-modify-write.
module saed32_32x4_rmw_ctrl
    import saed32_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_A0,
    output logic [DATA_W-1:0] mem_D0,
    output logic              mem_WE0,
    output logic              mem_CE0,
    output logic [DATA_W-1:0] mem_WEM0,
    input  logic [DATA_W-1:0] mem_Q0
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] mem_d_q;
    logic              mem_ce_q;
    logic              mem_we_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rdata_q;

    logic              idle_live;
    logic              accept;
    logic              full_write;
    logic              partial_write;
    logic [DATA_W-1:0] merged;

    // IDLE drives the memory straight from the request; gating with RSTN keeps the
    // port quiet while reset is held even though the state already reads IDLE.
    assign idle_live     = RSTN && (state == IDLE);
    assign req_ready     = idle_live && (!rsp_valid_q || rsp_ready);
    assign accept        = req_valid && req_ready;
    assign full_write    = req_we && (&req_wmask);
    assign partial_write = req_we && (|req_wmask) && !(&req_wmask);
    assign merged        = DATA_W'(merge_bits(MERGE_W'(mem_Q0), MERGE_W'(wdata_q), MERGE_W'(mask_q)));

    assign mem_CE0   = idle_live ? (accept && (!req_we || (|req_wmask))) : mem_ce_q;
    assign mem_WE0   = idle_live ? (accept && full_write) : mem_we_q;
    assign mem_A0    = idle_live ? req_addr : addr_q;
    assign mem_D0    = idle_live ? req_wdata : mem_d_q;
    assign mem_WEM0  = '1;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            mem_d_q     <= '0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!req_we) begin
                            state <= RD_WAIT;
                        end else if (partial_write) begin
                            state   <= RMW_RD;
                            addr_q  <= req_addr;
                            wdata_q <= req_wdata;
                            mask_q  <= req_wmask;
                        end
                    end
                end
                RD_WAIT: begin
                    rsp_valid_q <= 1'b1;
                    rdata_q     <= mem_Q0;
                    state       <= IDLE;
                end
                // The old word is merged on capture so RMW_WR drives purely registered data.
                RMW_RD: begin
                    mem_d_q  <= merged;
                    mem_ce_q <= 1'b1;
                    mem_we_q <= 1'b1;
                    state    <= RMW_WR;
                end
                RMW_WR: begin
                    mem_ce_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_saed32_32x4_rmw_ctrl.sv
// Bench for saed32_32x4_rmw_ctrl: behavioural SRAM, cycle-scheduled reference model,
// vector table, directed corner sequences and random traffic.
module tb_saed32_32x4_rmw_ctrl;

    logic       CLK;
    logic       RSTN;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [4:0] req_addr;
    logic [3:0] req_wdata;
    logic [3:0] req_wmask;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_rdata;
    logic [4:0] mem_A0;
    logic [3:0] mem_D0;
    logic       mem_WE0;
    logic       mem_CE0;
    logic [3:0] mem_WEM0;
    logic [3:0] mem_Q0;

    logic [3:0] sram [32];
    logic [3:0] sram_q;

    saed32_32x4_rmw_ctrl dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_A0    (mem_A0),
        .mem_D0    (mem_D0),
        .mem_WE0   (mem_WE0),
        .mem_CE0   (mem_CE0),
        .mem_WEM0  (mem_WEM0),
        .mem_Q0    (mem_Q0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_CE0) begin
            if (mem_WE0) sram[mem_A0] <= (sram[mem_A0] & ~mem_WEM0) | (mem_D0 & mem_WEM0);
            else         sram_q <= sram[mem_A0];
        end
    end
    assign mem_Q0 = sram_q;

    int tests;
    int fails;
    int cyc;

    // Reference model: memory image plus absolute cycle numbers for pending events.
    logic [3:0] ref_mem [32];
    int         idle_from;
    bit         rv;
    logic [3:0] rd;
    bit         clr_next;
    bit         rsp_pend;
    int         rsp_at;
    logic [3:0] pend_data;
    bit         wr_pend;
    int         wr_at;
    logic [4:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] wr_mask;

    bit         s_acc;
    logic       s_ready, s_rv, s_ce, s_we;
    logic [3:0] s_d, s_rdata;

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [3:0] wdata;
        logic [3:0] mask;
        logic       exp_ce;
        logic       exp_we;
        int         exp_busy;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_expired(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic model_reset();
        rv        = 1'b0;
        rd        = '0;
        clr_next  = 1'b0;
        rsp_pend  = 1'b0;
        wr_pend   = 1'b0;
        idle_from = 0;
    endtask

    task automatic check_output();
        bit         er, ece, ewe;
        logic [4:0] ea;
        logic [3:0] ed;
        if (clr_next) rv = 1'b0;
        clr_next = 1'b0;
        if (rsp_pend && cyc == rsp_at) begin
            rv       = 1'b1;
            rd       = pend_data;
            rsp_pend = 1'b0;
        end
        er    = (cyc >= idle_from) && (!rv || rsp_ready);
        ece   = 1'b0;
        ewe   = 1'b0;
        ea    = '0;
        ed    = '0;
        s_acc = req_valid && er;
        if (s_acc) begin
            if (!req_we) begin
                ece       = 1'b1;
                ea        = req_addr;
                pend_data = ref_mem[req_addr];
                rsp_pend  = 1'b1;
                rsp_at    = cyc + 2;
                idle_from = cyc + 2;
            end else if (req_wmask == 4'hF) begin
                ece = 1'b1;
                ewe = 1'b1;
                ea  = req_addr;
                ed  = req_wdata;
                ref_mem[req_addr] = req_wdata;
            end else if (req_wmask != 4'h0) begin
                ece       = 1'b1;
                ea        = req_addr;
                wr_pend   = 1'b1;
                wr_at     = cyc + 2;
                wr_addr   = req_addr;
                wr_data   = req_wdata;
                wr_mask   = req_wmask;
                idle_from = cyc + 3;
            end
        end else if (wr_pend && cyc == wr_at) begin
            ece = 1'b1;
            ewe = 1'b1;
            ea  = wr_addr;
            ed  = (ref_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
            ref_mem[wr_addr] = ed;
            wr_pend = 1'b0;
        end
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(rv));
        if (rv) chk("rsp_rdata", 32'(rsp_rdata), 32'(rd));
        chk("mem_CE0", 32'(mem_CE0), 32'(ece));
        chk("mem_WE0", 32'(mem_WE0), 32'(ewe));
        if (ece) chk("mem_A0", 32'(mem_A0), 32'(ea));
        if (ewe) chk("mem_D0", 32'(mem_D0), 32'(ed));
        chk("mem_WEM0", 32'(mem_WEM0), 32'hF);
        clr_next = rv && rsp_ready;
        s_ready  = req_ready;
        s_rv     = rsp_valid;
        s_rdata  = rsp_rdata;
        s_ce     = mem_CE0;
        s_we     = mem_WE0;
        s_d      = mem_D0;
    endtask

    task automatic apply_stimulus(input bit v, input bit we, input logic [4:0] a,
                                  input logic [3:0] d, input logic [3:0] m, input bit rr);
        @(posedge CLK);
        cyc++;
        #1;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        rsp_ready = rr;
        @(negedge CLK);
        check_output();
    endtask

    task automatic send(input bit we, input logic [4:0] a, input logic [3:0] d, input logic [3:0] m);
        int n;
        n = 0;
        do begin
            apply_stimulus(1'b1, we, a, d, m, 1'b1);
            n++;
        end while (!s_acc && n < 20);
        if (!s_acc) bound_expired("send");
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 5'd0, 4'h0, 4'h0, 1'b1);
    endtask

    // Drives a write request during reset to show the memory port stays forced off.
    task automatic do_reset();
        RSTN      = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 5'h11;
        req_wdata = 4'hF;
        req_wmask = 4'hF;
        rsp_ready = 1'b1;
        #1;
        chk("rst_ce", 32'(mem_CE0), 32'h0);
        chk("rst_we", 32'(mem_WE0), 32'h0);
        chk("rst_a0", 32'(mem_A0), 32'h0);
        chk("rst_d0", 32'(mem_D0), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        RSTN      = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        model_reset();
    endtask

    initial begin
        logic [3:0] wd [32];
        logic [3:0] old_val;
        int         n;
        logic [3:0] m;

        tests = 0;
        fails = 0;
        cyc   = 0;
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = '0;
            sram[i]    = '0;
            wd[i]      = 4'(i * 7 + 3);
        end
        sram_q    = '0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b1;
        RSTN      = 1'b1;
        model_reset();
        #2;
        do_reset();

        for (int i = 0; i < 32; i++) begin
            apply_stimulus(1'b1, 1'b1, 5'(i), wd[i], 4'hF, 1'b1);
            chk("b2b_write_we", 32'(s_we), 32'h1);
        end
        for (int i = 0; i < 32; i++) begin
            send(1'b0, 5'(i), 4'h0, 4'h0);
            idle(2);
            chk("b2b_rsp_valid", 32'(s_rv), 32'h1);
            chk("b2b_rdata", 32'(s_rdata), 32'(wd[i]));
        end

        vecs[0] = '{1'b0, 5'd5,  4'h0, 4'h0, 1'b1, 1'b0, 1};
        vecs[1] = '{1'b1, 5'd5,  4'hA, 4'hF, 1'b1, 1'b1, 0};
        vecs[2] = '{1'b1, 5'd7,  4'hF, 4'h0, 1'b0, 1'b0, 0};
        vecs[3] = '{1'b1, 5'd3,  4'h3, 4'h5, 1'b1, 1'b0, 2};
        vecs[4] = '{1'b0, 5'd3,  4'h0, 4'h0, 1'b1, 1'b0, 1};
        vecs[5] = '{1'b1, 5'd31, 4'h6, 4'h8, 1'b1, 1'b0, 2};
        vecs[6] = '{1'b1, 5'd0,  4'h9, 4'hF, 1'b1, 1'b1, 0};
        vecs[7] = '{1'b0, 5'd31, 4'h0, 4'h0, 1'b1, 1'b0, 1};
        for (int v = 0; v < 8; v++) begin
            apply_stimulus(1'b1, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].mask, 1'b1);
            chk("vec_ce", 32'(s_ce), 32'(vecs[v].exp_ce));
            chk("vec_we", 32'(s_we), 32'(vecs[v].exp_we));
            n = 0;
            do begin
                idle(1);
                if (!s_ready) n++;
            end while (!s_ready && n < 8);
            chk("vec_busy", 32'(n), 32'(vecs[v].exp_busy));
        end

        // Full write then immediate read of the same word.
        send(1'b1, 5'd5, 4'hA, 4'hF);
        chk("raw_write_we", 32'(s_we), 32'h1);
        send(1'b0, 5'd5, 4'h0, 4'h0);
        idle(1);
        chk("raw_t1_valid", 32'(s_rv), 32'h0);
        idle(1);
        chk("raw_t2_valid", 32'(s_rv), 32'h1);
        chk("raw_t2_rdata", 32'(s_rdata), 32'hA);

        // Partial write merge on a preloaded word.
        send(1'b1, 5'd3, 4'b1100, 4'hF);
        send(1'b1, 5'd3, 4'b0011, 4'b0101);
        chk("rmw_t0_ce", 32'(s_ce), 32'h1);
        chk("rmw_t0_we", 32'(s_we), 32'h0);
        idle(1);
        chk("rmw_t1_ready", 32'(s_ready), 32'h0);
        chk("rmw_t1_ce", 32'(s_ce), 32'h0);
        idle(1);
        chk("rmw_t2_ready", 32'(s_ready), 32'h0);
        chk("rmw_t2_we", 32'(s_we), 32'h1);
        chk("rmw_t2_d0", 32'(s_d), 32'b1001);
        idle(1);
        chk("rmw_t3_ready", 32'(s_ready), 32'h1);

        // Response back-pressure for five cycles with a competing request offered.
        send(1'b0, 5'd3, 4'h0, 4'h0);
        apply_stimulus(1'b1, 1'b0, 5'd4, 4'h0, 4'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b1, 1'b0, 5'd4, 4'h0, 4'h0, 1'b0);
            chk("stall_valid", 32'(s_rv), 32'h1);
            chk("stall_rdata", 32'(s_rdata), 32'b1001);
            chk("stall_ready", 32'(s_ready), 32'h0);
            chk("stall_ce", 32'(s_ce), 32'h0);
        end
        idle(1);
        chk("stall_release_valid", 32'(s_rv), 32'h1);
        idle(1);
        chk("stall_cleared", 32'(s_rv), 32'h0);

        // Mask-zero write leaves memory untouched.
        old_val = ref_mem[7];
        send(1'b1, 5'd7, ~old_val, 4'h0);
        chk("mask0_ce", 32'(s_ce), 32'h0);
        idle(2);
        chk("mask0_mem", 32'(sram[7]), 32'(old_val));

        // Reset pulsed while the merged write is on the port.
        old_val = ref_mem[9];
        send(1'b1, 5'd9, ~old_val, 4'b0110);
        idle(1);
        @(posedge CLK);
        cyc++;
        #1;
        chk("rst_rmw_we_before", 32'(mem_WE0), 32'h1);
        do_reset();
        chk("rst_rmw_mem", 32'(sram[9]), 32'(old_val));
        send(1'b0, 5'd9, 4'h0, 4'h0);
        idle(2);
        chk("rst_rmw_readback", 32'(s_rdata), 32'(old_val));

        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0:       m = 4'h0;
                1:       m = 4'hF;
                default: m = 4'($urandom_range(1, 14));
            endcase
            apply_stimulus(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                           5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), m,
                           1'($urandom_range(0, 3) != 0));
        end
        idle(4);
        for (int i = 0; i < 32; i++) chk("final_mem", 32'(sram[i]), 32'(ref_mem[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
